// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle of the dual-clock FIFO: requester handshake, memory write
// port, Gray pointer exchange and full flag.
interface fifo_wr_arbiter_if #(
    parameter int ADDRSIZE = 5,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [ADDRSIZE:0]     wq2_rptr;
    logic [NREQ-1:0]       gnt;
    logic                  wen;
    logic [ADDRSIZE-1:0]   waddr;
    logic [DSIZE-1:0]      wdata;
    logic [ADDRSIZE:0]     wptr;
    logic                  wfull;

    modport master (
        output req, req_data, wq2_rptr,
        input  gnt, wen, waddr, wdata, wptr, wfull
    );

    modport slave (
        input  req, req_data, wq2_rptr,
        output gnt, wen, waddr, wdata, wptr, wfull
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the dual-clock FIFO: owns the write
// pointer (binary + Gray), drives the memory write port and the full flag.
module fifo_wr_arbiter #(
    parameter int ADDRSIZE = 5,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ADDRSIZE:0]   wbin_r;
    logic [ADDRSIZE:0]   wptr_r;
    logic [ADDRSIZE-1:0] waddr_r;
    logic [DSIZE-1:0]    wdata_r;
    logic                wen_r;
    logic                wfull_r;
    logic [IW-1:0]       last_r;

    logic [IW-1:0]       pick_s;
    logic                accept_s;
    logic [NREQ-1:0]     gnt_s;
    logic [DSIZE-1:0]    sel_data_s;
    logic [ADDRSIZE:0]   wbinnext_s;
    logic [ADDRSIZE:0]   wgraynext_s;
    logic                full_next_s;

    // Round-robin pick: scan downward so the candidate closest to last+1 is written last and wins.
    always_comb begin
        pick_s = last_r;
        for (int k = NREQ; k >= 1; k--) begin
            pick_s = bus.req[(int'(last_r) + k) % NREQ] ? IW'((int'(last_r) + k) % NREQ) : pick_s;
        end
        accept_s    = !wrst && !wfull_r && (|bus.req);
        gnt_s       = accept_s ? ({{(NREQ-1){1'b0}}, 1'b1} << pick_s) : {NREQ{1'b0}};
        sel_data_s  = bus.req_data[int'(pick_s)*DSIZE +: DSIZE];
        wbinnext_s  = wbin_r + {{ADDRSIZE{1'b0}}, accept_s};
        wgraynext_s = (wbinnext_s >> 1) ^ wbinnext_s;
        // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
        full_next_s = (wgraynext_s == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]});
    end

    // Pointer, write-port and arbitration state update.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_r  <= {(ADDRSIZE+1){1'b0}};
            wptr_r  <= {(ADDRSIZE+1){1'b0}};
            waddr_r <= {ADDRSIZE{1'b0}};
            wdata_r <= {DSIZE{1'b0}};
            wen_r   <= 1'b0;
            wfull_r <= 1'b0;
            last_r  <= IW'(NREQ-1);
        end else begin
            wbin_r  <= wbinnext_s;
            wptr_r  <= wgraynext_s;
            wfull_r <= full_next_s;
            wen_r   <= accept_s;
            if (accept_s) begin
                waddr_r <= wbin_r[ADDRSIZE-1:0];
                wdata_r <= sel_data_s;
                last_r  <= pick_s;
            end
        end
    end

    assign bus.gnt   = gnt_s;
    assign bus.wen   = wen_r;
    assign bus.waddr = waddr_r;
    assign bus.wdata = wdata_r;
    assign bus.wptr  = wptr_r;
    assign bus.wfull = wfull_r;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a deep instance (ADDRSIZE=5) for arbitration
// and a shallow one (ADDRSIZE=2) for full/wrap, with write-port scoreboards.
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DSIZE = 8;
    localparam int AA = 5;
    localparam int AB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.ADDRSIZE(AA), .DSIZE(DSIZE), .NREQ(NREQ)) ifa ();
    fifo_wr_arbiter_if #(.ADDRSIZE(AB), .DSIZE(DSIZE), .NREQ(NREQ)) ifb ();

    fifo_wr_arbiter #(.ADDRSIZE(AA), .DSIZE(DSIZE), .NREQ(NREQ)) dut_a (.wclk(clk), .wrst(rst), .bus(ifa.slave));
    fifo_wr_arbiter #(.ADDRSIZE(AB), .DSIZE(DSIZE), .NREQ(NREQ)) dut_b (.wclk(clk), .wrst(rst), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;
    int wbin_a = 0;
    int wbin_b = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] ea;
    logic [15:0] eb;
    logic [7:0]  da[4];
    logic [7:0]  db[4];
    logic [2:0]  h1;
    logic [2:0]  h2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] gray(input int b);
        return 32'(b ^ (b >> 1));
    endfunction

    // Write-port monitors: pop one expected word per observed write strobe.
    always @(posedge clk) begin
        #2;
        if (ifa.wen) begin
            if (qa.size() == 0) flag("a_unexpected_wen", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("a_waddr", 32'(ifa.waddr), 32'(ea[15:8]));
                chk("a_wdata", 32'(ifa.wdata), 32'(ea[7:0]));
            end
        end else if (qa.size() != 0) begin
            flag("a_missing_wen", 0, 1);
            void'(qa.pop_front());
        end
        if (ifb.wen) begin
            if (qb.size() == 0) flag("b_unexpected_wen", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("b_waddr", 32'(ifb.waddr), 32'(eb[15:8]));
                chk("b_wdata", 32'(ifb.wdata), 32'(eb[7:0]));
            end
        end else if (qb.size() != 0) begin
            flag("b_missing_wen", 0, 1);
            void'(qb.pop_front());
        end
    end

    task automatic drive_data();
        ifa.req_data = {da[3], da[2], da[1], da[0]};
        ifb.req_data = {db[3], db[2], db[1], db[0]};
    endtask

    // Called just after a falling edge: apply req, check grant, queue expected write.
    task automatic cyc_a(input logic [3:0] r, input logic [3:0] exp_gnt);
        ifa.req = r;
        drive_data();
        #1;
        chk("a_gnt", 32'(ifa.gnt), 32'(exp_gnt));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) begin
                qa.push_back({8'(wbin_a % 32), da[i]});
                wbin_a++;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic [3:0] r, input logic [3:0] exp_gnt);
        ifb.req = r;
        drive_data();
        #1;
        chk("b_gnt", 32'(ifb.gnt), 32'(exp_gnt));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) begin
                qb.push_back({8'(wbin_b % 4), db[i]});
                wbin_b++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        da = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        db = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        rst = 1'b1;
        ifa.req = 4'b0000;
        ifb.req = 4'b0000;
        ifa.wq2_rptr = 6'd0;
        ifb.wq2_rptr = 3'd0;
        drive_data();
        @(negedge clk);

        // Reset held two cycles with all requesters active
        ifa.req = 4'b1111;
        #1;
        chk("rst_gnt_c1", 32'(ifa.gnt), 32'h0);
        @(negedge clk);
        chk("rst_gnt_c2", 32'(ifa.gnt), 32'h0);
        chk("rst_wen", 32'(ifa.wen), 32'h0);
        chk("rst_wptr", 32'(ifa.wptr), 32'h0);
        chk("rst_wfull", 32'(ifa.wfull), 32'h0);
        rst = 1'b0;

        // Round-robin rotation, 8 words
        for (int n = 0; n < 2; n++) begin
            cyc_a(4'b1111, 4'b0001);
            cyc_a(4'b1111, 4'b0010);
            cyc_a(4'b1111, 4'b0100);
            cyc_a(4'b1111, 4'b1000);
        end
        chk("a_wptr_after_rr", 32'(ifa.wptr), gray(8));

        // Skip and priority
        cyc_a(4'b1111, 4'b0001);
        cyc_a(4'b1001, 4'b1000);
        cyc_a(4'b1001, 4'b0001);
        cyc_a(4'b0100, 4'b0100);
        cyc_a(4'b0000, 4'b0000);
        chk("a_wptr_after_skip", 32'(ifa.wptr), gray(12));
        chk("a_wfull_low", 32'(ifa.wfull), 32'h0);

        // Full on the shallow instance
        for (int n = 0; n < 4; n++) cyc_b(4'b0001, 4'b0001);
        chk("b_full_after4", 32'(ifb.wfull), 32'h1);
        chk("b_wptr_after4", 32'(ifb.wptr), 32'(3'b110));
        cyc_b(4'b0001, 4'b0000);
        ifb.wq2_rptr = 3'b001;
        cyc_b(4'b0001, 4'b0000);
        chk("b_full_released", 32'(ifb.wfull), 32'h0);
        cyc_b(4'b0001, 4'b0001);
        chk("b_full_again", 32'(ifb.wfull), 32'h1);
        chk("b_wptr_after5", 32'(ifb.wptr), 32'(3'b111));
        cyc_b(4'b0001, 4'b0000);

        // Reset while full with requests pending
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(ifb.gnt), 32'h0);
        @(negedge clk);
        chk("mid_rst_wfull", 32'(ifb.wfull), 32'h0);
        chk("mid_rst_wptr", 32'(ifb.wptr), 32'h0);
        chk("mid_rst_wen", 32'(ifb.wen), 32'h0);
        rst = 1'b0;
        wbin_a = 0;
        wbin_b = 0;
        ifb.wq2_rptr = 3'd0;
        cyc_b(4'b1111, 4'b0001);

        // Wrap: read pointer trails the write pointer by two cycles
        h1 = ifb.wptr;
        h2 = ifb.wptr;
        for (int k = 0; k < 20; k++) begin
            ifb.wq2_rptr = h2;
            h2 = h1;
            h1 = ifb.wptr;
            db[0] = 8'(k * 7 + 3);
            cyc_b(4'b0001, 4'b0001);
            chk("wrap_wfull", 32'(ifb.wfull), 32'h0);
            chk("wrap_wptr", 32'(ifb.wptr), gray(wbin_b % 8));
        end
        cyc_b(4'b0000, 4'b0000);
        cyc_a(4'b0000, 4'b0000);

        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
